// File: rtl/dmem_responder.sv
// dmem_responder: data-store responder with word RAM, MMIO output FIFO and debug read port.
// Define DMEM_RESP_DROP_CNT_EN to build the saturating drop counter; otherwise drop_cnt reads 0.
module dmem_responder #(
    parameter int          ADDR_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_OUT   = 32'hFFFF_FFF0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              mem_we,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              fifo_full,
    output logic [15:0]       drop_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0] ram  [0:(1<<ADDR_W)-1];
    logic [31:0] fifo [0:FIFO_DEPTH-1];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        mmio_hit;
    logic        ram_we;
    logic        push_req;
    logic        full;
    logic        pop;
    logic        push;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign out_valid = (wr_ptr != rd_ptr);
    assign fifo_full = full;
    assign out_data  = fifo[rd_ptr[PW-1:0]];
    assign pop       = out_valid && out_ready;

    assign mmio_hit  = (mem_addr == MMIO_OUT);
    assign push_req  = mem_we && mmio_hit;
    assign ram_we    = mem_we && !mmio_hit && ((mem_addr >> ADDR_W) == 32'd0);
    assign push      = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[mem_addr[ADDR_W-1:0]] <= mem_data;
        if (push)
            fifo[wr_ptr[PW-1:0]] <= mem_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dbg_rdata <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PW+1)'(1);
            dbg_rdata <= ram[dbg_addr];
        end
    end

`ifdef DMEM_RESP_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_q <= '0;
        else if (push_req && full && !pop && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios plus randomized traffic checked
// against a queue/array reference model of the store port.
module tb_dmem_responder;
    localparam logic [31:0] MMIO = 32'hFFFF_FFF0;
`ifdef DMEM_RESP_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        mem_we = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        fifo_full;
    logic [15:0] drop_cnt;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata;

    int vecs = 0;
    int errs = 0;

    dmem_responder #(.ADDR_W(8), .FIFO_DEPTH(4), .MMIO_OUT(MMIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_full(fifo_full), .drop_cnt(drop_cnt),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_we = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1;
        mem_addr = a;
        mem_data = d;
        tick();
        mem_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vecs++;
        if (out_valid !== 1'b0 || fifo_full !== 1'b0 || drop_cnt !== 16'd0 ||
            dbg_rdata !== 32'd0) begin
            errs++;
            $display("FAIL reset_state: got v=%b f=%b d=%h r=%h want 0 0 0 0",
                     out_valid, fifo_full, drop_cnt, dbg_rdata);
        end
        rst_n = 1'b1;
        tick();
        store(MMIO, 32'hA);
        store(MMIO, 32'hB);
        vecs++;
        if (out_valid !== 1'b1 || out_data !== 32'hA) begin
            errs++;
            $display("FAIL pre_reset_queue: got v=%b d=%h want 1 0000000a",
                     out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if (out_valid !== 1'b0 || fifo_full !== 1'b0 || drop_cnt !== 16'd0) begin
            errs++;
            $display("FAIL async_reset: got v=%b f=%b d=%h want 0 0 0",
                     out_valid, fifo_full, drop_cnt);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        do_reset();
        dbg_addr = 8'd5;
        store(32'd5, 32'h1111_1111);
        store(32'd5, 32'hDEAD_BEEF);
        vecs++;
        if (dbg_rdata !== 32'h1111_1111) begin
            errs++;
            $display("FAIL ram_read_old: got %h want 11111111", dbg_rdata);
        end
        tick();
        vecs++;
        if (dbg_rdata !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL ram_readback: got %h want deadbeef", dbg_rdata);
        end
    endtask

    task automatic test_mmio_order();
        do_reset();
        for (int i = 1; i <= 4; i++)
            store(MMIO, i);
        vecs++;
        if (fifo_full !== 1'b1 || out_valid !== 1'b1) begin
            errs++;
            $display("FAIL mmio_full: got f=%b v=%b want 1 1", fifo_full, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            vecs++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                errs++;
                $display("FAIL mmio_order: got v=%b d=%h want 1 %h",
                         out_valid, out_data, 32'(i));
            end
            tick();
        end
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mmio_empty: got v=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] want [4];
        logic [15:0] exp_drop;
        exp_drop = CNT_EN ? 16'd2 : 16'd0;
        do_reset();
        for (int i = 1; i <= 4; i++)
            store(MMIO, i);
        store(MMIO, 32'd5);
        store(MMIO, 32'd6);
        vecs++;
        if (drop_cnt !== exp_drop || fifo_full !== 1'b1 || out_data !== 32'd1) begin
            errs++;
            $display("FAIL overflow: got d=%h f=%b h=%h want %h 1 00000001",
                     drop_cnt, fifo_full, out_data, exp_drop);
        end
        out_ready = 1'b1;
        store(MMIO, 32'd7);
        out_ready = 1'b0;
        vecs++;
        if (drop_cnt !== exp_drop || fifo_full !== 1'b1) begin
            errs++;
            $display("FAIL full_push_pop: got d=%h f=%b want %h 1",
                     drop_cnt, fifo_full, exp_drop);
        end
        want = '{32'd2, 32'd3, 32'd4, 32'd7};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (out_valid !== 1'b1 || out_data !== want[i]) begin
                errs++;
                $display("FAIL drain_order: got v=%b d=%h want 1 %h",
                         out_valid, out_data, want[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL drain_empty: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        dbg_addr = 8'd44;
        store(32'd44, 32'hA5A5_A5A5);
        store(32'd300, 32'h1234_5678);
        store(32'd256, 32'h8765_4321);
        tick();
        vecs++;
        if (dbg_rdata !== 32'hA5A5_A5A5 || out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            errs++;
            $display("FAIL out_of_range: got r=%h v=%b d=%h want a5a5a5a5 0 0",
                     dbg_rdata, out_valid, drop_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] ram_m [256];
        bit          known [256];
        int          drops;
        logic [31:0] exp_dbg;
        bit          exp_known;
        bit          do_pop;
        bit          was_full;
        logic [15:0] exp_drop;
        int          sel;
        do_reset();
        drops = 0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 5);
            mem_we = ($urandom_range(0, 3) != 0);
            mem_data = $urandom;
            case (sel)
                0, 1: mem_addr = MMIO;
                2, 3: mem_addr = $urandom_range(0, 15);
                4: mem_addr = 32'd256 + $urandom_range(0, 100);
                default: mem_addr = $urandom | 32'h0000_0100;
            endcase
            out_ready = ($urandom_range(0, 2) == 0);
            dbg_addr = 8'($urandom_range(0, 15));
            exp_dbg = ram_m[dbg_addr];
            exp_known = known[dbg_addr];
            do_pop = (q.size() > 0) && out_ready;
            was_full = (q.size() == 4);
            tick();
            if (do_pop) void'(q.pop_front());
            if (mem_we && mem_addr == MMIO) begin
                if (!was_full || do_pop) q.push_back(mem_data);
                else if (drops < 65535) drops++;
            end else if (mem_we && mem_addr < 32'd256) begin
                ram_m[mem_addr[7:0]] = mem_data;
                known[mem_addr[7:0]] = 1'b1;
            end
            exp_drop = CNT_EN ? 16'(drops) : 16'd0;
            vecs++;
            if (out_valid !== (q.size() != 0) || fifo_full !== (q.size() == 4) ||
                drop_cnt !== exp_drop) begin
                errs++;
                $display("FAIL rand_status[%0d]: got v=%b f=%b d=%h want %b %b %h",
                         n, out_valid, fifo_full, drop_cnt,
                         q.size() != 0, q.size() == 4, exp_drop);
            end
            if (q.size() != 0) begin
                vecs++;
                if (out_data !== q[0]) begin
                    errs++;
                    $display("FAIL rand_head[%0d]: got %h want %h", n, out_data, q[0]);
                end
            end
            if (exp_known) begin
                vecs++;
                if (dbg_rdata !== exp_dbg) begin
                    errs++;
                    $display("FAIL rand_dbg[%0d]: got %h want %h", n, dbg_rdata, exp_dbg);
                end
            end
        end
        mem_we = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_mmio_order();
        test_overflow();
        test_out_of_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-store port. Each cycle it samples `mem_addr`/`mem_data`/`mem_we` and commits stores to a word-addressed data RAM, or to an output FIFO when the address hits the MMIO output register. The FIFO drains to a downstream consumer (UART/LED driver) over a valid/ready stream. A registered debug read port lets the bench and board logic inspect RAM contents.

## Interface
Parameters:
- `ADDR_W`, 8: RAM depth is 2**ADDR_W 32-bit words.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `MMIO_OUT`, 32'hFFFF_FFF0: word address of the output register.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_addr`  in  32  store word address from the core.
- `mem_data`  in  32  store data.
- `mem_we`  in  1  store strobe; sampled every cycle.
- `out_data`  out  32  FIFO head word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head this cycle.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH entries.
- `drop_cnt`  out  16  stores lost to a full FIFO.
- `dbg_addr`  in  ADDR_W  debug read address.
- `dbg_rdata`  out  32  registered RAM word at `dbg_addr`.

## Operation
- Address decode happens only when `mem_we`=1:
  - `mem_addr == MMIO_OUT`: push `mem_data` into the FIFO.
  - `mem_addr < 2**ADDR_W`: write `RAM[mem_addr[ADDR_W-1:0]] <= mem_data`.
  - Any other address: no effect; not counted.
- FIFO:
  - Pop when `out_valid && out_ready`.
  - `out_data` is the head entry; it is undefined-but-stable when empty, and the consumer must ignore it in that case.
  - Push while full with no pop in the same cycle: the word is dropped and `drop_cnt` increments, saturating at 16'hFFFF.
  - Push and pop in the same cycle while full: both occur; no drop; occupancy unchanged.
  - Push and pop in the same cycle while empty: impossible, because `out_valid`=0.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH. Full is MSBs differing with the rest equal; empty is the pointers equal.
- Debug port: `dbg_rdata <= RAM[dbg_addr]` every cycle. A read and a write to the same address in the same cycle return the old word.
- Reset: FIFO pointers 0, `out_valid`=0, `fifo_full`=0, `drop_cnt`=0, `dbg_rdata`=0. RAM contents are not reset. A push in flight when reset asserts is lost.

## Timing
- Store to RAM: written at edge N. The new value is visible on `dbg_rdata` after edge N+1 when `dbg_addr` is held.
- Store to MMIO into an empty FIFO: `out_valid` rises after edge N, with `out_data` equal to the stored word (1-cycle latency).
- Pop at edge N: the next head appears after edge N. `out_valid` falls after edge N if that pop emptied the FIFO.
- Sustained throughput: one push and one pop per cycle.
- `fifo_full` and `drop_cnt` are registered and update at the same edge as the push or drop.

## Configuration
- `DMEM_RESP_DROP_CNT_EN` defined: the drop counter is implemented as specified.
- `DMEM_RESP_DROP_CNT_EN` undefined:
  - no counter register is built, and `drop_cnt` is tied to 0;
  - stores to a full FIFO without a simultaneous pop are still silently dropped.

## Test plan
- Reset mid-stream: with 2 entries queued, pulse `rst_n` low asynchronously -> `out_valid`=0, `fifo_full`=0, `drop_cnt`=0 immediately, before the next edge.
- RAM store/readback: store 32'hDEADBEEF to address 5, set `dbg_addr`=5 -> `dbg_rdata`=32'hDEADBEEF one edge after the store edge. A read issued in the same cycle as the write returns the old value.
- MMIO ordering: `out_ready`=0, store 1, 2, 3, 4 to MMIO_OUT -> `fifo_full`=1. Then raise `out_ready` -> `out_data` reads 1, 2, 3, 4 on consecutive cycles, and `out_valid` drops after the fourth.
- Overflow: FIFO full with `out_ready`=0, store 5 and 6 -> `drop_cnt`=2 and the FIFO still holds 1..4.
- Full with simultaneous push/pop: FIFO full, `out_ready`=1, store 7 -> no drop, and 7 is drained last after 2..4.
- Out-of-range address: store to address 300 (ADDR_W=8) -> RAM unchanged, FIFO unchanged, `drop_cnt` unchanged.
